// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
//
// Purpose: request/response bus between an initiator and data_mem_responder.
//   The initiator raises req_valid with a command and holds it until it sees
//   req_ready. The responder answers with a one-cycle rsp_valid strobe that
//   carries rsp_rdata and rsp_err.
//
// Parameters:
//   XLEN  data/address width; must match the XLEN of the attached responder.
//
// Signals:
//   req_valid  initiator -> responder  request present
//   req_ready  responder -> initiator  request accepted this cycle
//   req_we     initiator -> responder  1 = write, 0 = read
//   req_be     initiator -> responder  byte-lane write enables
//   req_addr   initiator -> responder  byte address
//   req_wdata  initiator -> responder  lane-aligned write data
//   rsp_valid  responder -> initiator  one-cycle response strobe
//   rsp_rdata  responder -> initiator  read word (0 for writes)
//   rsp_err    responder -> initiator  request rejected
//   busy       responder -> initiator  a request is in flight
//
// Modports: master (initiator side), slave (responder side).
// ----------------------------------------------------------------------------
interface data_mem_responder_if #(
  parameter int XLEN = 32
);

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [3:0]      req_be;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic            busy;

  modport master (
    output req_valid,
    output req_we,
    output req_be,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_be,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err,
    output busy
  );

endinterface

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//
// Purpose: single-ported word memory behind a valid/ready request bus with a
//   fixed number of wait states. One request is handled at a time:
//     IDLE --handshake--> WAIT (WAIT cycles) --> RESP (1 cycle) --> IDLE
//   With WAIT = 0 the handshake goes straight to RESP. Writes are committed
//   and reads are sampled on the clock edge that enters RESP, so the response
//   strobe is seen WAIT+1 cycles after the handshake edge and a new request
//   can be accepted every WAIT+2 cycles.
//
// Parameters:
//   XLEN   data/address width (at least 32, four byte lanes are used)
//   DEPTH  number of XLEN-bit words, power of two
//   WAIT   wait-state cycles between accept and response, 0..15
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    data_mem_responder_if.slave (request/response bus and busy)
//
// Optional feature (macro DMEM_ALIGN_CHECK_EN):
//   defined   -> writes must use a naturally aligned byte enable pattern
//                (word at offset 0, half-word at offset 0 or 2, or a single
//                byte at its own offset). Anything else leaves memory
//                untouched and answers rsp_err=1, rsp_rdata=0 with the
//                normal latency.
//   undefined -> rsp_err is tied low, addr[1:0] is ignored and req_be is
//                applied as given.
//
// The storage array is never reset; its contents survive reset pulses.
// ----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int WAIT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT);
  localparam bit         DIRECT    = (WAIT == 0);

  typedef enum logic [1:0] {
    stIdle,
    stWait,
    stResp
  } stateT;

  stateT           state;
  stateT           nextState;
  logic [3:0]      cnt;
  logic [3:0]      cntNext;

  logic [XLEN-1:0] mem [DEPTH];

  // Registered copy of the accepted request.
  logic [AW-1:0]   idxQ;
  logic [1:0]      offQ;
  logic            weQ;
  logic [3:0]      beQ;
  logic [XLEN-1:0] wdataQ;

  logic [XLEN-1:0] rdataQ;

  logic            handshake;
  logic            enterResp;

  // Fields used on the commit edge (live bus or registered copy).
  logic [AW-1:0]   cmtIdx;
  logic [1:0]      cmtOff;
  logic            cmtWe;
  logic [3:0]      cmtBe;
  logic [XLEN-1:0] cmtWdata;
  logic            cmtIllegal;
  logic            cmtWrite;

  // Upper address bits only alias the array (wrap modulo DEPTH words).
  logic            unusedAddrHigh;
  assign unusedAddrHigh = ^bus.req_addr[XLEN-1:AW+2];

  // req_ready also depends on reset so nothing is accepted while reset is
  // held, even in the same cycle the reset is released.
  assign handshake = bus.req_valid && bus.req_ready;

  // State register and wait counter. An asynchronous reset anywhere in a
  // request drops back to IDLE, which is what aborts an in-flight write:
  // the commit only ever happens on the edge that enters RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= stIdle;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
    end
  end

  // Next-state logic. The counter is loaded with WAIT on the handshake and
  // decremented every WAIT cycle; at a count of one the next edge enters
  // RESP. RESP always lasts exactly one cycle. A request presented while
  // busy is simply not seen because req_ready is low.
  always_comb begin
    nextState = state;
    cntNext   = cnt;
    enterResp = 1'b0;
    unique case (state)
      stIdle: begin
        if (handshake) begin
          if (DIRECT) begin
            nextState = stResp;
            enterResp = 1'b1;
            cntNext   = '0;
          end else begin
            nextState = stWait;
            cntNext   = WAIT_INIT;
          end
        end
      end
      stWait: begin
        if (cnt <= 4'd1) begin
          nextState = stResp;
          enterResp = 1'b1;
          cntNext   = '0;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      stResp: begin
        nextState = stIdle;
      end
      default: begin
        nextState = stIdle;
        cntNext   = '0;
      end
    endcase
  end

  // Capture the accepted request so the bus is free to change while we wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idxQ   <= '0;
      offQ   <= '0;
      weQ    <= 1'b0;
      beQ    <= '0;
      wdataQ <= '0;
    end else if (handshake) begin
      idxQ   <= bus.req_addr[AW+1:2];
      offQ   <= bus.req_addr[1:0];
      weQ    <= bus.req_we;
      beQ    <= bus.req_be;
      wdataQ <= bus.req_wdata;
    end
  end

  // With no wait states the commit edge is the handshake edge itself, so the
  // registered copy is not valid yet and the live bus fields are used.
  always_comb begin
    if (DIRECT) begin
      cmtIdx   = bus.req_addr[AW+1:2];
      cmtOff   = bus.req_addr[1:0];
      cmtWe    = bus.req_we;
      cmtBe    = bus.req_be;
      cmtWdata = bus.req_wdata;
    end else begin
      cmtIdx   = idxQ;
      cmtOff   = offQ;
      cmtWe    = weQ;
      cmtBe    = beQ;
      cmtWdata = wdataQ;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // Accepted write shapes: full word at offset 0, half-word at offset 0 or
  // 2, or a single byte whose lane matches the offset. An empty byte mask
  // matches none of these and is rejected too.
  function automatic logic alignedWrite(input logic [3:0] be,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if ((be == 4'b1111) && (off == 2'b00)) ok = 1'b1;
    if ((be == 4'b0011) && (off == 2'b00)) ok = 1'b1;
    if ((be == 4'b1100) && (off == 2'b10)) ok = 1'b1;
    if (be == (4'b0001 << off))            ok = 1'b1;
    return ok;
  endfunction

  assign cmtIllegal = cmtWe && !alignedWrite(cmtBe, cmtOff);
`else
  logic unusedOffset;
  assign unusedOffset = ^cmtOff;
  assign cmtIllegal   = 1'b0;
`endif

  assign cmtWrite = enterResp && cmtWe && !cmtIllegal;

  // Storage array: byte-lane writes on the RESP entry edge. Deliberately has
  // no reset so its contents are preserved across reset pulses.
  always_ff @(posedge clk) begin
    if (cmtWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (cmtBe[i]) begin
          mem[cmtIdx][8*i +: 8] <= cmtWdata[8*i +: 8];
        end
      end
    end
  end

  // Response word is sampled on the same edge as the write commit. Reads
  // return the whole word whatever the byte mask; writes (and rejected
  // writes) return zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdataQ <= '0;
    end else if (enterResp) begin
      rdataQ <= cmtWe ? '0 : mem[cmtIdx];
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic errQ;

  // Error flag travels with the response word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      errQ <= 1'b0;
    end else if (enterResp) begin
      errQ <= cmtIllegal;
    end
  end

  assign bus.rsp_err = errQ;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = (state == stIdle) && reset;
  assign bus.rsp_valid = (state == stResp);
  assign bus.rsp_rdata = rdataQ;
  assign bus.busy      = (state != stIdle);

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Self-checking bench for data_mem_responder (XLEN=32, DEPTH=1024, WAIT=2).
// Directed vectors come from a table; multi-cycle corner cases (reset
// behaviour, held req_valid, reset during a write) are hand-written; a
// randomized phase is checked against a word/byte-level memory model.
// Expected values follow DMEM_ALIGN_CHECK_EN when the macro is defined.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int XLEN  = 32;
  localparam int DEPTH = 1024;
  localparam int WAIT  = 2;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  data_mem_responder_if #(.XLEN(XLEN)) bus ();

  data_mem_responder #(
    .XLEN (XLEN),
    .DEPTH(DEPTH),
    .WAIT (WAIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
    string       name;
  } tbVector;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] modelMem [DEPTH];
  tbVector     vecs [$];

  // Watchdog: every wait below is bounded, this only guards the unexpected.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int wordIndex(input logic [31:0] addr);
    return int'((addr / 32'd4) % DEPTH);
  endfunction

  function automatic bit legalWrite(input logic [3:0] be, input logic [1:0] off);
    case ({be, off})
      {4'b1111, 2'd0}, {4'b0011, 2'd0}, {4'b1100, 2'd2},
      {4'b0001, 2'd0}, {4'b0010, 2'd1}, {4'b0100, 2'd2},
      {4'b1000, 2'd3}: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  task automatic modelAccess(input logic we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] expR, output logic expE);
    int idx;
    idx  = wordIndex(addr);
    expE = ALIGN && we && !legalWrite(be, addr[1:0]);
    expR = 32'h0;
    if (!we) begin
      expR = modelMem[idx];
    end else if (!expE) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) modelMem[idx][8*k +: 8] = wdata[8*k +: 8];
      end
    end
  endtask

  // ---------------- bus driver ----------------
  // Starts and ends on a falling edge with the DUT idle. Reports how many
  // cycles were spent waiting for ready and the response latency counted in
  // cycles from the handshake edge.
  task automatic applyStimulus(input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err,
                               output int waitEdges, output int latency);
    rdata         = 32'hBAD0BAD0;
    err           = 1'bx;
    bus.req_we    = we;
    bus.req_be    = be;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    #1;
    waitEdges = 0;
    while (!bus.req_ready && waitEdges < 20) begin
      @(negedge clk);
      waitEdges++;
    end
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      latency = -1;
      $display("[TB] FAIL readyTimeout: got req_ready=0 for %0d cycles, expected 1", waitEdges);
      mismatched++;
      compared++;
      return;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    latency = 1;
    while (!bus.rsp_valid && latency < WAIT + 10) begin
      @(negedge clk);
      latency++;
    end
    if (bus.rsp_valid) begin
      rdata = bus.rsp_rdata;
      err   = bus.rsp_err;
    end
    @(negedge clk);
    checkOutput("rspOneCycle", 32'(bus.rsp_valid), 32'h0);
  endtask

  task automatic runTxn(input string name, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] expR, input logic expE);
    logic [31:0] rdata;
    logic        err;
    int          waitEdges;
    int          latency;
    applyStimulus(we, be, addr, wdata, rdata, err, waitEdges, latency);
    checkOutput({name, ".rdata"}, rdata, expR);
    checkOutput({name, ".err"}, 32'(err), 32'(expE));
    checkOutput({name, ".latency"}, 32'(latency), 32'(WAIT + 1));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] mr;
    logic        me;
    logic [31:0] rdata;
    logic        err;
    int          waitEdges;
    int          latency;
    int          hsCount;
    int          rspCount;
    int          hsT [2];
    int          rspT [2];
    int          rspSeen;

    // Reset state, with a request pending to show it is not accepted.
    reset         = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_be    = 4'hF;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("resetReqReady", 32'(bus.req_ready), 32'h0);
    checkOutput("resetRspValid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("resetRspRdata", bus.rsp_rdata, 32'h0);
    checkOutput("resetRspErr",   32'(bus.rsp_err), 32'h0);
    checkOutput("resetBusy",     32'(bus.busy), 32'h0);

    // First handshake on the first rising edge after reset release.
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    modelAccess(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, mr, me);
    applyStimulus(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rdata, err, waitEdges, latency);
    checkOutput("firstHandshakeWait", 32'(waitEdges), 32'h0);
    checkOutput("firstWrite.latency", 32'(latency), 32'(WAIT + 1));
    checkOutput("firstWrite.rdata", rdata, 32'h0);

    // Directed vectors.
    vecs.push_back('{1'b0, 4'hF, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0,  "rdWord10"});
    vecs.push_back('{1'b1, 4'hF, 32'h20,   32'h11223344, 32'h0,        1'b0,  "wrWord20"});
    vecs.push_back('{1'b1, 4'h4, 32'h22,   32'h00AA0000, 32'h0,        1'b0,  "wrByte22"});
    vecs.push_back('{1'b0, 4'hF, 32'h20,   32'h0,        32'h11AA3344, 1'b0,  "rdByteMerge"});
    vecs.push_back('{1'b1, 4'hF, 32'h1000, 32'h00000055, 32'h0,        1'b0,  "wrWrap1000"});
    vecs.push_back('{1'b0, 4'hF, 32'h0,    32'h0,        32'h00000055, 1'b0,  "rdWrap0"});
    vecs.push_back('{1'b1, 4'hF, 32'h30,   32'h0,        32'h0,        1'b0,  "wrZero30"});
    vecs.push_back('{1'b1, 4'hF, 32'h40,   32'hCAFEF00D, 32'h0,        1'b0,  "wrWord40"});
    vecs.push_back('{1'b1, 4'h0, 32'h40,   32'hFFFFFFFF, 32'h0,        ALIGN, "wrEmptyMask"});
    vecs.push_back('{1'b0, 4'hF, 32'h40,   32'h0,        32'hCAFEF00D, 1'b0,  "rdAfterEmpty"});
    vecs.push_back('{1'b1, 4'h3, 32'h41,   32'h00001234, 32'h0,        ALIGN, "wrMisalignHalf"});
    vecs.push_back('{1'b0, 4'hF, 32'h40,   32'h0,
                     ALIGN ? 32'hCAFEF00D : 32'hCAFE1234, 1'b0,  "rdAfterMisalign"});
    vecs.push_back('{1'b0, 4'h0, 32'h13,   32'h0,        32'hDEADBEEF, 1'b0,  "rdNoMaskOffset"});
    vecs.push_back('{1'b1, 4'h8, 32'h23,   32'h99000000, 32'h0,        1'b0,  "wrTopByte"});
    vecs.push_back('{1'b0, 4'hF, 32'h20,   32'h0,        32'h99AA3344, 1'b0,  "rdTopByte"});

    foreach (vecs[i]) begin
      modelAccess(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, mr, me);
      runTxn(vecs[i].name, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
             vecs[i].expRdata, vecs[i].expErr);
    end

    // req_valid held through WAIT/RESP: second request only after response.
    bus.req_we    = 1'b0;
    bus.req_be    = 4'hF;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h0;
    bus.req_valid = 1'b1;
    #1;
    hsCount  = 0;
    rspCount = 0;
    hsT      = '{-1, -1};
    rspT     = '{-1, -1};
    for (int t = 0; t < 4 * (WAIT + 2); t++) begin
      if (bus.rsp_valid) begin
        if (rspCount < 2) rspT[rspCount] = t;
        rspCount++;
        checkOutput("heldRdata", bus.rsp_rdata, 32'hDEADBEEF);
      end
      if (bus.req_valid && bus.req_ready) begin
        if (hsCount < 2) hsT[hsCount] = t;
        hsCount++;
      end
      @(negedge clk);
      if (hsCount >= 2) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    checkOutput("heldHandshakes", 32'(hsCount), 32'd2);
    checkOutput("heldResponses", 32'(rspCount), 32'd2);
    checkOutput("heldFirstLatency", 32'(rspT[0] - hsT[0]), 32'(WAIT + 1));
    checkOutput("heldThroughput", 32'(hsT[1] - hsT[0]), 32'(WAIT + 2));
    checkOutput("heldSecondAfterRsp", 32'(hsT[1] > rspT[0]), 32'd1);

    // Reset pulsed during WAIT of a write to 0x30: write aborted, no response.
    bus.req_we    = 1'b1;
    bus.req_be    = 4'hF;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h12345678;
    bus.req_valid = 1'b1;
    #1;
    checkOutput("abortReady", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("abortBusyInWait", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("abortBusyInReset", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset   = 1'b1;
    rspSeen = 0;
    repeat (WAIT + 4) begin
      @(negedge clk);
      if (bus.rsp_valid) rspSeen++;
    end
    checkOutput("abortNoResponse", 32'(rspSeen), 32'd0);
    runTxn("rdAfterAbort", 1'b0, 4'hF, 32'h30, 32'h0, 32'h0, 1'b0);

    // Randomized phase: seed a small window of words, then random traffic
    // with aliased upper address bits, random offsets, masks and idle gaps.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] d;
      d = $urandom;
      modelAccess(1'b1, 4'hF, 32'(i * 4), d, mr, me);
      runTxn("rndInit", 1'b1, 4'hF, 32'(i * 4), d, mr, me);
    end
    for (int n = 0; n < 150; n++) begin
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      we    = 1'($urandom_range(0, 1));
      be    = 4'($urandom_range(0, 15));
      addr  = (32'($urandom_range(0, 7)) << 12) | (32'($urandom_range(0, 15)) << 2)
              | 32'($urandom_range(0, 3));
      wdata = $urandom;
      modelAccess(we, be, addr, wdata, mr, me);
      runTxn(we ? "rndWrite" : "rndRead", we, be, addr, wdata, mr, me);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter DEPTH, default 1024, number of XLEN-bit words stored (power of two).
REQ-003 SHALL have parameter WAIT, default 2, wait-state cycles between accept and response (0..15).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  1  initiator presents a request.
REQ-007 SHALL have port req_ready  output  1  block accepts request this cycle.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_be  input  4  byte-lane write enables, lane i = wdata[8i+7:8i].
REQ-010 SHALL have port req_addr  input  XLEN  byte address.
REQ-011 SHALL have port req_wdata  input  XLEN  write data, lane-aligned.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-013 SHALL have port rsp_rdata  output  XLEN  read word, valid with rsp_valid.
REQ-014 SHALL have port rsp_err  output  1  request rejected, valid with rsp_valid.
REQ-015 SHALL have port busy  output  1  request in flight (state != IDLE).

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE with reset deasserted; handshake = req_valid & req_ready at rising edge.
REQ-018 On handshake SHALL register addr, we, be, wdata; go to WAIT loading counter with WAIT, or to RESP directly if WAIT=0.
REQ-019 In WAIT SHALL decrement counter each cycle; at counter=1 transition to RESP.
REQ-020 On the edge entering RESP SHALL commit a write (only lanes with be=1) and register the read word; rsp_valid=1 for exactly that one RESP cycle; next state IDLE unconditionally.
REQ-021 Response latency SHALL be WAIT+1 cycles from handshake edge to rsp_valid; throughput one request per WAIT+2 cycles.
REQ-022 Word index SHALL be req_addr[log2(DEPTH)+1:2]; upper address bits ignored (wrap modulo DEPTH words).
REQ-023 Reads SHALL return the full word regardless of be; writes SHALL return rsp_rdata=0.
REQ-024 req_valid during WAIT/RESP SHALL be ignored (not accepted, not queued); initiator holds it until ready.
REQ-025 be=0000 write SHALL complete normally with no memory change.
REQ-026 Memory array SHALL not be initialised or cleared by reset.

Reset
REQ-027 While reset=0: state IDLE, counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
REQ-028 Reset asserted mid-request SHALL abort it: no write committed, no response issued.
REQ-029 First handshake SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro DMEM_ALIGN_CHECK_EN defined: write legal only if be=1111 with addr[1:0]=00, be=0011<<off with off in {00,10}, or be=0001<<off; illegal write performs no memory change and responds rsp_err=1, rsp_rdata=0, same latency.
REQ-031 Macro DMEM_ALIGN_CHECK_EN undefined: rsp_err tied 0; addr[1:0] ignored; be applied as given.

Verification
REQ-032 WAIT=2: write addr 0x10 data 0xDEADBEEF be 1111, then read 0x10 -> rsp_valid 3 cycles after each handshake, read rsp_rdata=0xDEADBEEF.
REQ-033 Byte write: word 0x20=0x11223344, write be 0100 wdata 0x00AA0000 -> read 0x20 returns 0x11AA3344.
REQ-034 Wrap: DEPTH=1024, write 0x55 at addr 0x1000, read addr 0x0 -> 0x00000055.
REQ-035 req_valid held during WAIT -> req_ready=0, second request accepted only in IDLE after rsp_valid; exactly two responses.
REQ-036 reset pulsed low during WAIT of a write to 0x30 (old 0x0) -> no rsp_valid, later read 0x30 returns 0x0.
REQ-037 DMEM_ALIGN_CHECK_EN: write be 0011 addr 0x41 -> rsp_err=1, word 0x40 unchanged; undefined: rsp_err=0, lanes 0-1 written.
